// File: rtl/zeroskip_tile_ctrl.sv
// Tile sequencer for the zero-skip MAC row.
// It gates the input beat stream into the row and inserts one zero pad beat
// for odd-length 8:32 tiles. It also counts encoded output beats, flags the
// last one, and pulses done once the tile has drained.
module zeroskip_tile_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             cfg_nz_sel_i,
  input  logic [CNT_W-1:0] cfg_beats_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             group_nz_sel_o,
  input  logic             src_vld_i,
  output logic             src_rdy_o,
  output logic             row_vld_o,
  input  logic             row_rdy_i,
  output logic             row_pad_o,
  input  logic             enc_vld_i,
  input  logic             enc_rdy_i,
  output logic             enc_last_o,
  output logic             ovf_err_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_PAD   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic [CNT_W-1:0] exp_q, exp_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             ovf_q, ovf_d;

  logic             start_ok_s;
  logic             in_xfer_s;
  logic             in_last_s;
  logic             out_hs_s;
  logic             counting_s;
  logic             out_full_s;
  logic             out_done_s;
  logic [CNT_W-1:0] exp_calc_s;

  // Output-beat target: halving in 8:32 mode rounds up so the pad beat is counted.
  // The sum cannot exceed 2^(CNT_W-1), so it never wraps.
  assign exp_calc_s = cfg_nz_sel_i ? cfg_beats_i
                                   : ((cfg_beats_i >> 1) + {{(CNT_W-1){1'b0}}, cfg_beats_i[0]});

  assign start_ok_s = (state_q == S_IDLE) && start_i;
  assign in_xfer_s  = (state_q == S_FEED) && src_vld_i && row_rdy_i;
  assign in_last_s  = in_xfer_s && (in_cnt_q == (beats_q - ONE));
  assign out_hs_s   = enc_vld_i && enc_rdy_i;
  assign counting_s = (state_q == S_FEED) || (state_q == S_PAD) || (state_q == S_DRAIN);
  assign out_full_s = (out_cnt_q == exp_q);
  assign out_done_s = out_full_s || (out_hs_s && (out_cnt_q == (exp_q - ONE)));

  assign enc_last_o     = busy_o && (out_cnt_q == (exp_q - ONE));
  assign ovf_err_o      = ovf_q;
  assign group_nz_sel_o = mode_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; output completion seen early is resolved in DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = (cfg_beats_i == '0) ? S_DONE : S_FEED;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FEED: begin
        if (in_last_s) begin
          state_d = (!mode_q && beats_q[0]) ? S_PAD : S_DRAIN;
        end else begin
          state_d = S_FEED;
        end
      end
      S_PAD: begin
        if (row_rdy_i) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_PAD;
        end
      end
      S_DRAIN: begin
        if (out_done_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake gating and status outputs decoded from the current state.
  always_comb begin
    row_vld_o = 1'b0;
    src_rdy_o = 1'b0;
    row_pad_o = 1'b0;
    busy_o    = 1'b1;
    done_o    = 1'b0;
    case (state_q)
      S_IDLE: busy_o = 1'b0;
      S_FEED: begin
        row_vld_o = src_vld_i;
        src_rdy_o = row_rdy_i;
      end
      S_PAD: begin
        row_vld_o = 1'b1;
        row_pad_o = 1'b1;
      end
      S_DRAIN: busy_o = 1'b1;
      S_DONE:  done_o = 1'b1;
      default: busy_o = 1'b0;
    endcase
  end

  // Tile configuration latch and beat counters.
  // out_cnt saturates at the target; any handshake beyond it raises ovf.
  always_comb begin
    mode_d    = mode_q;
    beats_d   = beats_q;
    exp_d     = exp_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    ovf_d     = ovf_q;
    if (start_ok_s) begin
      mode_d    = cfg_nz_sel_i;
      beats_d   = cfg_beats_i;
      exp_d     = exp_calc_s;
      in_cnt_d  = '0;
      out_cnt_d = '0;
      ovf_d     = 1'b0;
    end else begin
      if (in_xfer_s) begin
        in_cnt_d = in_cnt_q + ONE;
      end else begin
        in_cnt_d = in_cnt_q;
      end
      if (out_hs_s && counting_s && !out_full_s) begin
        out_cnt_d = out_cnt_q + ONE;
      end else begin
        out_cnt_d = out_cnt_q;
      end
      if (out_hs_s && ((state_q == S_IDLE) || out_full_s)) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= 1'b0;
      beats_q   <= '0;
      exp_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      beats_q   <= beats_d;
      exp_q     <= exp_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: doc/zeroskip_tile_ctrl.md
# zeroskip_tile_ctrl

Tile sequencer for the MAC1024 zero-skip row datapath. Accepts a tile command (beat count plus sparsity mode), gates the input beat stream into the row, holds the row's mode select stable for the whole tile, and pads odd-length 8:32 tiles with one zero beat so the 16-to-32 byte combiner never strands half a word. It also counts encoded output beats, marks the last one, and pulses done once the tile has fully drained.

## Interface
Parameters:
- CNT_W, 16, width of beat counters and of cfg_beats_i.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  tile start pulse; sampled only in IDLE.
- cfg_nz_sel_i  in  1  mode: 0 = 8:32, 1 = 16:32; latched at accepted start.
- cfg_beats_i  in  CNT_W  input beats in the tile; latched at accepted start.
- busy_o  out  1  high from the accepted start to the end of DONE, inclusive.
- done_o  out  1  one-cycle pulse in DONE.
- group_nz_sel_o  out  1  latched mode, drives the row's group_nz_sel.
- src_vld_i  in  1  upstream znz/act beat valid (both streams already joined).
- src_rdy_o  out  1  upstream ready.
- row_vld_o  out  1  beat valid into the row.
- row_rdy_i  in  1  row input ready.
- row_pad_o  out  1  row input muxes force znz and act to all-zero for this beat.
- enc_vld_i  in  1  row output valid (observed).
- enc_rdy_i  in  1  row output ready (observed).
- enc_last_o  out  1  current row output beat is the last of the tile.
- ovf_err_o  out  1  sticky: output handshake seen with no beats expected.

## Operation
- States: IDLE, FEED, PAD, DRAIN, DONE.
- IDLE: src_rdy_o = row_vld_o = 0. start_i latches the cfg inputs, clears counters and ovf_err_o, and moves to FEED. If cfg_beats_i == 0, the block goes to DONE instead.
- Expected output beats: exp = beats when mode = 1; exp = ceil(beats/2) when mode = 0. exp is computed at start in CNT_W bits, and beats = 2^CNT_W-1 must not overflow.
- FEED: row_vld_o = src_vld_i and src_rdy_o = row_rdy_i, combinationally. in_cnt increments on each src_vld_i && row_rdy_i. When the final beat transfers:
  - mode 0 with odd beats goes to PAD;
  - every other case goes to DRAIN.
- PAD: row_vld_o = 1, row_pad_o = 1, src_rdy_o = 0. Holds until row_rdy_i, then goes to DRAIN.
- Output counting runs in FEED, PAD and DRAIN. out_cnt increments on each enc_vld_i && enc_rdy_i.
- enc_last_o = busy && (out_cnt == exp-1). It is combinational and qualified by nothing else.
- DRAIN: once out_cnt reaches exp, including the cycle in which the final handshake occurs, the block moves to DONE.
- Early completion: if out_cnt reaches exp while the block is still in FEED or PAD, it waits for input completion before DONE.
- DONE: done_o = 1 for one cycle, then IDLE.
- ovf_err_o: set when an output handshake occurs with out_cnt == exp, or occurs in IDLE. out_cnt saturates at exp.
- group_nz_sel_o changes only at an accepted start and is stable for the whole tile.

## Timing
- Reset values: every output is 0, state is IDLE, counters are 0, latched mode is 0.
- Start to first possible input transfer: 1 cycle (start at cycle t, FEED at t+1).
- Input path adds zero latency: row_vld_o and src_rdy_o are combinational through FEED.
- Final output handshake at cycle t gives done_o at t+1; IDLE follows at t+2.
- Earliest next start is accepted in the cycle after DONE.
- A zero-beat tile pulses done_o at t+1.
- start_i outside IDLE is ignored with no side effects.
- Asynchronous reset mid-tile returns to IDLE immediately. Any beat in flight is the datapath's concern, and the row FIFOs are reset by the same rst_n.

## Test plan
- Mode 1, beats = 4, row always ready, enc_rdy always 1:
  - 4 input transfers, no row_pad_o;
  - enc_last_o on the 4th output beat;
  - done_o one cycle after that beat.
- Mode 0, beats = 5:
  - 5 src transfers, then one PAD beat (row_pad_o = 1, src_rdy_o = 0);
  - exp = 3, enc_last_o on the 3rd output;
  - group_nz_sel_o = 0 throughout.
- Mode 0, beats = 4, with row_rdy_i toggled 1010 and enc_rdy_i stalled 3 cycles:
  - no PAD;
  - exactly 2 output beats counted;
  - busy_o held until done.
- beats = 0: done_o at t+1, no row_vld_o ever, busy_o high for exactly one cycle.
- start_i pulsed during FEED with different cfg: ignored, and group_nz_sel_o unchanged.
- Spurious extra enc_vld&&rdy after the last beat sets ovf_err_o, which is cleared by the next start.
- rst_n asserted mid-DRAIN: all outputs 0 asynchronously, and a new tile completes normally after release.
